// File: rtl/pci_master.sv
// PCI bus initiator: runs one address phase plus up to MAX_BURST IRDY/TRDY data phases per request.
// Latency: address phase the cycle after start; the shortest transaction is 3 clocks (ADDR, DATA, END).
// Backpressure: NTRED high stalls a data phase indefinitely once DEVSEL is seen; start is ignored while busy.
module pci_master #(
    parameter int         MAX_BURST      = 5,
    parameter int         DEVSEL_TIMEOUT = 5,
    parameter logic [3:0] CMD_WRITE      = 4'b0111,
    parameter logic [3:0] CMD_READ       = 4'b0110
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [31:0] Address_Data,
    output logic        NFRAME,
    output logic        NIRED,
    output logic [3:0]  C_BE,
    input  logic        NTRED,
    input  logic        NDEVSEL,
    input  logic        stop,
    input  logic        start,
    input  logic        write_nread,
    input  logic [31:0] start_addr,
    input  logic [2:0]  burst_len,
    input  logic [3:0]  byte_en,
    input  logic        buf_wr_en,
    input  logic [2:0]  buf_wr_idx,
    input  logic [31:0] buf_wr_data,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        master_abort,
    output logic        disconnected,
    output logic [2:0]  words_done
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_t;

    localparam logic [2:0] LP_MAX = 3'(MAX_BURST);
    localparam logic [2:0] LP_TMO = 3'(DEVSEL_TIMEOUT);

    state_t      r_state;
    logic        r_wr;
    logic [2:0]  r_len;
    logic [3:0]  r_be;
    logic [2:0]  r_phase;
    logic [2:0]  r_tmo;
    logic        r_devsel_seen;
    logic        r_nframe;
    logic        r_nirdy;
    logic        r_ad_oe;
    logic [31:0] r_ad_out;
    logic        r_cbe_oe;
    logic [3:0]  r_cbe;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_abort;
    logic        r_disc;
    logic [2:0]  r_words;
    logic [31:0] r_buf [MAX_BURST];

    // A target counts as selected from the first edge that samples NDEVSEL low.
    logic        w_devsel;
    logic        w_xfer;
    logic        w_last;
    logic        w_timeout;
    logic        w_stop;
    logic        w_finish;
    logic [2:0]  w_phase_nx;
    logic [2:0]  w_words;

    assign w_devsel   = r_devsel_seen | ~NDEVSEL;
    assign w_xfer     = w_devsel & ~NTRED;
    assign w_last     = w_xfer & (r_phase == r_len - 3'd1);
    assign w_timeout  = ~w_devsel & (r_tmo + 3'd1 == LP_TMO);
    assign w_stop     = w_devsel & ~stop;
    assign w_finish   = w_timeout | w_last | w_stop;
    assign w_phase_nx = r_phase + 3'd1;
    assign w_words    = r_phase + {2'b00, w_xfer};

    assign Address_Data = r_ad_oe  ? r_ad_out : 32'bz;
    assign C_BE         = r_cbe_oe ? r_cbe    : 4'bz;
    assign NFRAME       = r_nframe;
    assign NIRED        = r_nirdy;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign master_abort = r_abort;
    assign disconnected = r_disc;
    assign words_done   = r_words;

    // Write buffer: loadable only while idle, out-of-range indices dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_BURST; i++) r_buf[i] <= '0;
        end else if (buf_wr_en && r_state == S_IDLE && buf_wr_idx < LP_MAX) begin
            r_buf[buf_wr_idx] <= buf_wr_data;
        end
    end

    // Transaction FSM with registered bus and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_wr          <= 1'b0;
            r_len         <= '0;
            r_be          <= '0;
            r_phase       <= '0;
            r_tmo         <= '0;
            r_devsel_seen <= 1'b0;
            r_nframe      <= 1'b1;
            r_nirdy       <= 1'b1;
            r_ad_oe       <= 1'b0;
            r_ad_out      <= '0;
            r_cbe_oe      <= 1'b0;
            r_cbe         <= '0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_abort       <= 1'b0;
            r_disc        <= 1'b0;
            r_words       <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (burst_len == 3'd0 || burst_len > LP_MAX) begin
                            // Bad length: report an empty, clean completion without touching the bus.
                            r_done  <= 1'b1;
                            r_words <= '0;
                            r_abort <= 1'b0;
                            r_disc  <= 1'b0;
                        end else begin
                            r_state       <= S_ADDR;
                            r_busy        <= 1'b1;
                            r_wr          <= write_nread;
                            r_len         <= burst_len;
                            r_be          <= byte_en;
                            r_phase       <= '0;
                            r_tmo         <= '0;
                            r_devsel_seen <= 1'b0;
                            r_nframe      <= 1'b0;
                            r_nirdy       <= 1'b1;
                            r_ad_oe       <= 1'b1;
                            r_ad_out      <= start_addr;
                            r_cbe_oe      <= 1'b1;
                            r_cbe         <= write_nread ? CMD_WRITE : CMD_READ;
                        end
                    end
                end
                S_ADDR: begin
                    // Reads release AD here so the target owns it from the first data cycle.
                    r_state  <= S_DATA;
                    r_nirdy  <= 1'b0;
                    r_cbe    <= r_be;
                    r_ad_oe  <= r_wr;
                    r_ad_out <= r_buf[0];
                    r_nframe <= (r_len == 3'd1);
                end
                S_DATA: begin
                    r_devsel_seen <= w_devsel;
                    if (!w_devsel) r_tmo <= r_tmo + 3'd1;
                    if (w_xfer) begin
                        r_phase <= w_phase_nx;
                        if (!r_wr) begin
                            r_rd_data  <= Address_Data;
                            r_rd_valid <= 1'b1;
                        end
                    end
                    if (w_finish) begin
                        r_state  <= S_END;
                        r_nframe <= 1'b1;
                        r_nirdy  <= 1'b1;
                        r_ad_oe  <= 1'b0;
                        r_cbe_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_abort  <= w_timeout;
                        r_disc   <= w_stop & ~w_last;
                        r_words  <= w_timeout ? 3'd0 : w_words;
                    end else if (w_xfer) begin
                        // Present the next word; FRAME deasserts for the final phase.
                        r_ad_out <= r_buf[w_phase_nx];
                        r_nframe <= (w_phase_nx == r_len - 3'd1);
                    end
                end
                S_END: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pci_master.sv
module tb_pci_master;

    logic        clk = 1'b0;
    logic        reset;
    wire  [31:0] Address_Data;
    logic        NFRAME;
    logic        NIRED;
    wire  [3:0]  C_BE;
    logic        NTRED;
    logic        NDEVSEL;
    logic        stop;
    logic        start;
    logic        write_nread;
    logic [31:0] start_addr;
    logic [2:0]  burst_len;
    logic [3:0]  byte_en;
    logic        buf_wr_en;
    logic [2:0]  buf_wr_idx;
    logic [31:0] buf_wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        master_abort;
    logic        disconnected;
    logic [2:0]  words_done;

    logic [31:0] tb_ad;
    logic        tb_ad_oe;
    assign Address_Data = tb_ad_oe ? tb_ad : 32'bz;

    always #5 clk = ~clk;

    pci_master dut (
        .clk(clk), .reset(reset), .Address_Data(Address_Data),
        .NFRAME(NFRAME), .NIRED(NIRED), .C_BE(C_BE),
        .NTRED(NTRED), .NDEVSEL(NDEVSEL), .stop(stop),
        .start(start), .write_nread(write_nread), .start_addr(start_addr),
        .burst_len(burst_len), .byte_en(byte_en),
        .buf_wr_en(buf_wr_en), .buf_wr_idx(buf_wr_idx), .buf_wr_data(buf_wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .master_abort(master_abort), .disconnected(disconnected), .words_done(words_done)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: expected read words and expected {abort, disc, words} at done.
    logic [31:0] rd_q   [$];
    logic [4:0]  done_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a read word or a completion.
    always @(negedge clk) begin
        logic [31:0] e_rd;
        logic [4:0]  e_dn;
        if (rd_valid) begin
            check("rd_expected", 32'(rd_q.size() > 0), 32'd1);
            if (rd_q.size() > 0) begin
                e_rd = rd_q.pop_front();
                check("rd_data", rd_data, e_rd);
            end
        end
        if (done) begin
            check("done_expected", 32'(done_q.size() > 0), 32'd1);
            if (done_q.size() > 0) begin
                e_dn = done_q.pop_front();
                check("done_status", 32'({master_abort, disconnected, words_done}), 32'(e_dn));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] idx, input logic [31:0] d);
        buf_wr_en   = 1'b1;
        buf_wr_idx  = idx;
        buf_wr_data = d;
        tick();
        buf_wr_en   = 1'b0;
    endtask

    // Issues a start pulse; returns in the cycle after the sampling edge.
    task automatic start_txn(input logic wr, input logic [31:0] addr, input logic [2:0] len);
        start       = 1'b1;
        write_nread = wr;
        start_addr  = addr;
        burst_len   = len;
        byte_en     = 4'hF;
        tick();
        start       = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; write_nread = 1'b0; start_addr = '0;
        burst_len = '0; byte_en = '0; buf_wr_en = 1'b0; buf_wr_idx = '0;
        buf_wr_data = '0; NTRED = 1'b1; NDEVSEL = 1'b1; stop = 1'b1;
        tb_ad = '0; tb_ad_oe = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_nframe", 32'(NFRAME), 32'd1);
        check("rst_nirdy", 32'(NIRED), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_words", 32'(words_done), 32'd0);
        check("rst_flags", 32'({master_abort, disconnected}), 32'd0);
        reset = 1'b1;
        tick();

        // 1: three-word write, immediate TRDY
        load(3'd0, 32'h0000_00A0);
        load(3'd1, 32'h0000_00A1);
        load(3'd2, 32'h0000_00A2);
        NDEVSEL = 1'b0; NTRED = 1'b0;
        done_q.push_back({1'b0, 1'b0, 3'd3});
        start_txn(1'b1, 32'h0, 3'd3);
        check("w3_addr", Address_Data, 32'h0);
        check("w3_cmd", 32'(C_BE), 32'h7);
        check("w3_addr_nframe", 32'(NFRAME), 32'd0);
        check("w3_addr_nirdy", 32'(NIRED), 32'd1);
        check("w3_busy", 32'(busy), 32'd1);
        buf_wr_en = 1'b1; buf_wr_idx = 3'd0; buf_wr_data = 32'hDEAD_BEEF;
        tick();
        buf_wr_en = 1'b0;
        check("w3_d0", Address_Data, 32'hA0);
        check("w3_be", 32'(C_BE), 32'hF);
        check("w3_d0_nframe", 32'(NFRAME), 32'd0);
        check("w3_d0_nirdy", 32'(NIRED), 32'd0);
        tick();
        check("w3_d1", Address_Data, 32'hA1);
        check("w3_d1_nframe", 32'(NFRAME), 32'd0);
        tick();
        check("w3_d2", Address_Data, 32'hA2);
        check("w3_d2_nframe", 32'(NFRAME), 32'd1);
        tick();
        check("w3_end_nframe", 32'(NFRAME), 32'd1);
        check("w3_end_nirdy", 32'(NIRED), 32'd1);
        check("w3_end_busy", 32'(busy), 32'd0);
        check("w3_end_done", 32'(done), 32'd1);
        tick();

        // 2: two-word read, one wait state before the first word
        NTRED = 1'b1;
        rd_q.push_back(32'h11);
        rd_q.push_back(32'h22);
        done_q.push_back({1'b0, 1'b0, 3'd2});
        start_txn(1'b0, 32'h1, 3'd2);
        check("r2_addr", Address_Data, 32'h1);
        check("r2_cmd", 32'(C_BE), 32'h6);
        tick();
        check("r2_wait_nirdy", 32'(NIRED), 32'd0);
        check("r2_wait_nframe", 32'(NFRAME), 32'd0);
        tick();
        check("r2_p0_nframe", 32'(NFRAME), 32'd0);
        tb_ad_oe = 1'b1; tb_ad = 32'h11; NTRED = 1'b0;
        tick();
        check("r2_p1_nframe", 32'(NFRAME), 32'd1);
        tb_ad = 32'h22;
        tick();
        tb_ad_oe = 1'b0;
        check("r2_end_nirdy", 32'(NIRED), 32'd1);
        tick();

        // 3: single-word write; also shows the busy-time load was dropped
        done_q.push_back({1'b0, 1'b0, 3'd1});
        start_txn(1'b1, 32'h4, 3'd1);
        tick();
        check("w1_nframe", 32'(NFRAME), 32'd1);
        check("w1_nirdy", 32'(NIRED), 32'd0);
        check("w1_data", Address_Data, 32'hA0);
        tick();
        check("w1_done", 32'(done), 32'd1);
        check("w1_words", 32'(words_done), 32'd1);
        tick();

        // 4: master abort, TRDY without DEVSEL must be ignored
        NDEVSEL = 1'b1; NTRED = 1'b0;
        done_q.push_back({1'b1, 1'b0, 3'd0});
        start_txn(1'b1, 32'h8, 3'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ma_wait_nirdy", 32'(NIRED), 32'd0);
        end
        tick();
        check("ma_nframe", 32'(NFRAME), 32'd1);
        check("ma_nirdy", 32'(NIRED), 32'd1);
        check("ma_flag", 32'(master_abort), 32'd1);
        tick();

        // 5: five-word write, target stops with TRDY on the second word
        load(3'd0, 32'hB0); load(3'd1, 32'hB1); load(3'd2, 32'hB2);
        load(3'd3, 32'hB3); load(3'd4, 32'hB4);
        NDEVSEL = 1'b0; NTRED = 1'b0;
        done_q.push_back({1'b0, 1'b1, 3'd2});
        start_txn(1'b1, 32'h10, 3'd5);
        tick();
        check("dc_d0", Address_Data, 32'hB0);
        tick();
        check("dc_d1", Address_Data, 32'hB1);
        stop = 1'b0;
        tick();
        stop = 1'b1;
        check("dc_nframe", 32'(NFRAME), 32'd1);
        check("dc_nirdy", 32'(NIRED), 32'd1);
        check("dc_disc", 32'(disconnected), 32'd1);
        check("dc_words", 32'(words_done), 32'd2);
        tick();

        // Rejected lengths: immediate empty completion, bus untouched
        done_q.push_back({1'b0, 1'b0, 3'd0});
        start_txn(1'b1, 32'h0, 3'd0);
        check("rej0_busy", 32'(busy), 32'd0);
        check("rej0_nframe", 32'(NFRAME), 32'd1);
        done_q.push_back({1'b0, 1'b0, 3'd0});
        start_txn(1'b1, 32'h0, 3'd6);
        check("rej6_busy", 32'(busy), 32'd0);
        tick();

        // 6: reset after the first word releases everything immediately
        start_txn(1'b1, 32'h20, 3'd3);
        tick();
        tick();
        check("rst_mid_d1", Address_Data, 32'hB1);
        reset = 1'b0;
        #1;
        check("rst_mid_nframe", 32'(NFRAME), 32'd1);
        check("rst_mid_nirdy", 32'(NIRED), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        tick();
        check("rst_mid_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick();
        done_q.push_back({1'b0, 1'b0, 3'd1});
        start_txn(1'b1, 32'h0, 3'd1);
        tick();
        check("rst_buf_clear", Address_Data, 32'h0);
        repeat (3) tick();

        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_master.md
Name: pci_master

Overview:
- PCI bus initiator; the other end of the existing PCI target block on the shared AD/C_BE bus.
- Accepts a burst request from a local agent and runs one PCI transaction: address phase, IRDY/TRDY-handshaked data phases, then frame end.
- Write data comes from an internal word buffer loaded by the local side. Read data is streamed back one word per completed data phase.
- Also handles target disconnect (stop) and master abort (no DEVSEL).

Parameters:
- MAX_BURST, 5, maximum data phases per transaction; also the write-buffer depth.
- DEVSEL_TIMEOUT, 5, clocks after the address phase to wait for NDEVSEL low before master abort.
- CMD_WRITE, 4'b0111, command driven on C_BE for writes.
- CMD_READ, 4'b0110, command driven on C_BE for reads.

Ports:
- clk, input, 1, bus clock; all bus inputs sampled and all outputs updated on posedge.
- reset, input, 1, asynchronous, active-low.
- Address_Data, inout, 32, multiplexed PCI address/data bus.
- NFRAME, output, 1, frame, active-low.
- NIRED, output, 1, initiator ready, active-low.
- C_BE, output, 4, command in address phase; byte enables in data phases (1 = byte enabled).
- NTRED, input, 1, target ready, active-low.
- NDEVSEL, input, 1, device select, active-low.
- stop, input, 1, target stop request, active-low.
- start, input, 1, one-clock request pulse; ignored while busy.
- write_nread, input, 1, 1 = write, 0 = read; sampled with start.
- start_addr, input, 32, transaction start address; sampled with start.
- burst_len, input, 3, number of data phases, 1..MAX_BURST; sampled with start.
- byte_en, input, 4, byte enables for every data phase; sampled with start.
- buf_wr_en, input, 1, write-buffer load strobe.
- buf_wr_idx, input, 3, write-buffer index.
- buf_wr_data, input, 32, write-buffer word.
- rd_data, output, 32, read word returned.
- rd_valid, output, 1, one-clock pulse per completed read data phase.
- busy, output, 1, transaction in progress.
- done, output, 1, one-clock pulse at transaction end.
- master_abort, output, 1, valid with done: no DEVSEL seen.
- disconnected, output, 1, valid with done: target stop ended the transfer early.
- words_done, output, 3, valid with done: number of completed data phases.

Behaviour:
- Reset (async, reset=0):
  - NFRAME=1, NIRED=1; Address_Data and C_BE released (z).
  - rd_data=0, rd_valid=0, busy=0, done=0, master_abort=0, disconnected=0, words_done=0.
  - Write buffer cleared to 0; FSM to IDLE.
  - Reset mid-transaction releases the bus immediately; no done pulse.
- IDLE:
  - buf_wr_en writes buf[buf_wr_idx]; loads are ignored when busy or idx>=MAX_BURST.
  - start=1 latches request, sets busy=1, moves to ADDR.
  - burst_len=0 or >MAX_BURST: request rejected, stay IDLE, done pulse with words_done=0, both status flags 0.
- ADDR (1 clk):
  - NFRAME=0, NIRED=1, Address_Data=start_addr, C_BE=CMD_WRITE or CMD_READ.
  - Next state DATA.
- DATA:
  - NIRED=0, C_BE=byte_en.
  - Write: Address_Data=buf[phase]. Read: Address_Data=z from the first DATA cycle (turnaround).
  - NFRAME=0, except NFRAME=1 during the final phase (phase==burst_len-1). For burst_len=1, NFRAME rises in the same cycle NIRED falls.
  - Transfer completes at a posedge sampling NIRED=0 and NTRED=0:
    - Increment phase.
    - Read: rd_data<=Address_Data and rd_valid=1 next cycle.
  - NTRED=1 is a wait state: hold all outputs and data; waits are unlimited once NDEVSEL=0.
  - Last transfer done: move to END.
  - stop=0 sampled: a transfer at the same edge (NTRED=0) counts; then move to END with disconnected=1.
  - stop=0 and last transfer at the same edge: END with disconnected=0.
  - NDEVSEL still 1 at DEVSEL_TIMEOUT clocks after the ADDR cycle: move to END with master_abort=1, words_done=0. Any NTRED=0 before DEVSEL is ignored.
- END (1 clk):
  - NFRAME=1, NIRED=1, bus and C_BE released.
  - done=1 with status flags and words_done; busy=0; back to IDLE.
  - A start in this cycle is ignored.
- Latency: start at edge N gives the address phase in cycle N+1. Minimum total for 1 word with immediate TRDY: ADDR, DATA, END = 3 clocks.
- Counters are 3-bit and never wrap; phase is bounded by burst_len.

Test Plan:
1. Load buf[0..2]=A0,A1,A2; start write, addr=0, len=3, be=4'hF; target TRDY immediate -> AD shows 0/A0/A1/A2 on consecutive cycles, C_BE 0111 then F, NFRAME high in A2 cycle, done with words_done=3.
2. Read, addr=1, len=2; target returns 0x11, 0x22 with one wait state before the first word -> rd_valid twice with 0x11 then 0x22, AD z from the cycle after ADDR.
3. Write, len=1 -> NFRAME=1 and NIRED=0 in the same cycle, done after 3 clocks, words_done=1.
4. No target responds (NDEVSEL stays 1) -> master_abort=1, words_done=0 at timeout 5, NFRAME/NIRED=1.
5. Write, len=5; target asserts stop=0 together with TRDY on word 2 -> disconnected=1, words_done=2, no further words driven.
6. reset=0 mid-burst after word 1 -> NFRAME/NIRED=1 and AD=z immediately; no done; busy=0; buffer reads back 0.
